conv_layer_sched: RTL and testbench

Sequencer for the 3×3 convolution engine and its partial-sum accumulator. It runs one layer by iterating over input channels. For each channel it requests an image/weight load, triggers the conv engine, and paces each output pixel with a delayed `save_done` pulse. It clears the accumulator before a conv2 run and reports completion to the top-level NPU control.

---
 rtl/conv_layer_sched.sv | 101 ++++++++++
 tb/tb_conv_layer_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: per-layer sequencer driving channel loads, conv triggers, pixel save pacing and accumulator control.
// Ports: clk/rst_n (async active-low); start/abort/layer/num_chan_m1/out_w/out_h run control;
// ld_req/ld_chan/ld_ack loader handshake; conv_trigger/conv_layer/conv_valid/conv_addr/save_done engine side;
// ps_clear/ps_ce accumulator control; busy/done/err status.
module conv_layer_sched #(
  parameter int MAX_CHAN = 16,
  parameter int SAVE_LAT = 3,
  parameter int ADDR_W = 8,
  localparam int CW = $clog2(MAX_CHAN),
  localparam int SW = $clog2(SAVE_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              layer,
  input  logic [CW-1:0]     num_chan_m1,
  input  logic [4:0]        out_w,
  input  logic [4:0]        out_h,
  output logic              ld_req,
  output logic [CW-1:0]     ld_chan,
  input  logic              ld_ack,
  output logic              conv_trigger,
  output logic              conv_layer,
  input  logic              conv_valid,
  input  logic [ADDR_W-1:0] conv_addr,
  output logic              save_done,
  output logic              ps_clear,
  output logic              ps_ce,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, TRIG, WAIT_PIX, SAVE, NEXT, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] nch_q, chan_cnt;
  logic [ADDR_W-1:0] pix_cnt, last_pix;
  logic [SW-1:0] sv_cnt, sv_nx;
  logic [9:0] prod;
  logic accept, pix_hit;
  assign ld_chan = chan_cnt;
  always_comb begin
    prod = {5'd0, out_w} * {5'd0, out_h} - 10'd1;
    accept = start && st == IDLE && !abort;
    pix_hit = conv_valid && st == WAIT_PIX && !abort;
    sv_nx = st == SAVE ? SW'(sv_cnt + 1'b1) : '0;
    nxt = st;
    case (st)
      IDLE:     nxt = start ? (layer ? CLEAR : LOAD) : IDLE;
      CLEAR:    nxt = LOAD;
      LOAD:     nxt = ld_ack ? TRIG : LOAD;
      TRIG:     nxt = WAIT_PIX;
      WAIT_PIX: nxt = conv_valid ? (conv_addr == last_pix ? NEXT : SAVE) : WAIT_PIX;
      SAVE:     nxt = sv_cnt == SW'(SAVE_LAT - 1) ? WAIT_PIX : SAVE;
      NEXT:     nxt = chan_cnt == nch_q ? DONE : LOAD;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      nch_q <= '0;
      chan_cnt <= '0;
      pix_cnt <= '0;
      last_pix <= '0;
      sv_cnt <= '0;
      ld_req <= 1'b0;
      conv_trigger <= 1'b0;
      conv_layer <= 1'b0;
      save_done <= 1'b0;
      ps_clear <= 1'b0;
      ps_ce <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= nxt;
      busy <= nxt != IDLE;
      ps_clear <= nxt == CLEAR;
      ld_req <= nxt == LOAD;
      conv_trigger <= nxt == TRIG;
      done <= nxt == DONE;
      sv_cnt <= nxt == SAVE ? sv_nx : '0;
      save_done <= nxt == SAVE && sv_nx == SW'(SAVE_LAT - 1);
      ps_ce <= nxt != IDLE && (accept ? layer : conv_layer);
      if (accept) begin
        conv_layer <= layer;
        nch_q <= layer ? num_chan_m1 : '0;
        last_pix <= ADDR_W'(prod);
        chan_cnt <= '0;
        err <= 1'b0;
      end
      if (st == NEXT && nxt == LOAD) chan_cnt <= chan_cnt + 1'b1;
      if (st == TRIG) pix_cnt <= '0;
      if (pix_hit && conv_addr != pix_cnt) err <= 1'b1;
      if (pix_hit && conv_addr != last_pix) pix_cnt <= pix_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed self-checking bench for conv_layer_sched.
module tb_conv_layer_sched;
  localparam int ADDR_W = 8;
  logic clk, rst_n, start, abort, layer, ld_ack, conv_valid;
  logic [3:0] num_chan_m1, ld_chan;
  logic [4:0] out_w, out_h;
  logic [ADDR_W-1:0] conv_addr;
  logic ld_req, conv_trigger, conv_layer, save_done, ps_clear, ps_ce, busy, done, err;
  int errors = 0, checks = 0;
  int n_save, n_trig, n_clear, n_done, n_ldrise, n_psce_bad, cyc, cyc_clear, cyc_ld;
  logic lay_exp, ld_prev;
  logic [12:0] outs;
  assign outs = {ld_req, ld_chan, conv_trigger, conv_layer, save_done, ps_clear, ps_ce, busy, done, err};

  conv_layer_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .layer(layer),
    .num_chan_m1(num_chan_m1), .out_w(out_w), .out_h(out_h),
    .ld_req(ld_req), .ld_chan(ld_chan), .ld_ack(ld_ack),
    .conv_trigger(conv_trigger), .conv_layer(conv_layer), .conv_valid(conv_valid),
    .conv_addr(conv_addr), .save_done(save_done), .ps_clear(ps_clear), .ps_ce(ps_ce),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (save_done) n_save++;
    if (conv_trigger) n_trig++;
    if (ps_clear) begin n_clear++; if (cyc_clear < 0) cyc_clear = cyc; end
    if (done) n_done++;
    if (ld_req && !ld_prev) begin n_ldrise++; if (cyc_ld < 0) cyc_ld = cyc; end
    if (ps_ce !== (busy & lay_exp)) n_psce_bad++;
    ld_prev = ld_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts(input logic lay);
    n_save = 0; n_trig = 0; n_clear = 0; n_done = 0; n_ldrise = 0; n_psce_bad = 0;
    cyc_clear = -1; cyc_ld = -1; lay_exp = lay;
  endtask

  task automatic do_start(input logic lay, input logic [3:0] nch, input logic [4:0] w, input logic [4:0] h);
    layer = lay; num_chan_m1 = nch; out_w = w; out_h = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Serves one channel: loader ack, then every pixel, checking save_done pacing.
  task automatic run_chan(input int ch, input int npix, input int skip, input bit last, input bit spur);
    int w = 0;
    while (!ld_req && w < 20) begin tick(); w++; end
    checks++;
    if (ld_req !== 1'b1) begin
      errors++; $display("FAIL ld_req_wait: ld_req=%0b want 1", ld_req); return;
    end
    checks++;
    if (ld_chan !== 4'(ch)) begin errors++; $display("FAIL ld_chan: got %0d want %0d", ld_chan, ch); end
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    checks++;
    if ({ld_req, conv_trigger} !== 2'b01) begin
      errors++; $display("FAIL trig: ld_req,conv_trigger=%b want 01", {ld_req, conv_trigger});
    end
    tick();
    for (int i = 0; i < npix; i++) begin
      if (spur && i == 2) begin
        ld_ack = 1'b1; start = 1'b1; layer = 1'b1; tick(); ld_ack = 1'b0; start = 1'b0; layer = 1'b0;
        checks++;
        if ({busy, ld_req, conv_trigger, ps_clear, save_done} !== 5'b10000) begin
          errors++; $display("FAIL spur_wait: got %b want 10000", {busy, ld_req, conv_trigger, ps_clear, save_done});
        end
      end
      conv_valid = 1'b1; conv_addr = ADDR_W'(i == skip ? i + 1 : i); tick(); conv_valid = 1'b0;
      checks++;
      if (save_done !== 1'b0) begin errors++; $display("FAIL save_early1 pix %0d: got %b want 0", i, save_done); end
      if (spur && i == 3) begin conv_valid = 1'b1; conv_addr = '0; end
      tick(); conv_valid = 1'b0;
      checks++;
      if (i == npix - 1) begin
        if (last && done !== 1'b1) begin errors++; $display("FAIL done_at_t2: got %b want 1", done); end
        if (!last && ld_req !== 1'b1) begin errors++; $display("FAIL next_ld_at_t2: got %b want 1", ld_req); end
      end else begin
        if (save_done !== 1'b0) begin errors++; $display("FAIL save_early2 pix %0d: got %b want 0", i, save_done); end
        tick();
        checks++;
        if (save_done !== 1'b1) begin errors++; $display("FAIL save_lat pix %0d: got %b want 1", i, save_done); end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; abort = 1'b0; layer = 1'b1; ld_ack = 1'b1; conv_valid = 1'b1; conv_addr = '0;
    num_chan_m1 = '0; out_w = 5'd1; out_h = 5'd1;
    rst_n = 1'b1; #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL reset_outs: got %b want 0", outs); end
    start = 1'b0; ld_ack = 1'b0; conv_valid = 1'b0; layer = 1'b0;
    rst_n = 1'b1; tick();
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL reset_idle: got %b want 0", outs); end
  endtask

  task automatic test_conv1();
    clr_counts(1'b0);
    do_start(1'b0, 4'd5, 5'd11, 5'd12);
    checks++;
    if ({busy, ld_req, ps_clear, ld_chan} !== 7'b1100000) begin
      errors++; $display("FAIL conv1_cycle1: got %b want 1100000", {busy, ld_req, ps_clear, ld_chan});
    end
    run_chan(0, 132, -1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({busy, done, err, conv_layer} !== 4'b0000) begin
      errors++; $display("FAIL conv1_end: busy,done,err,layer=%b want 0000", {busy, done, err, conv_layer});
    end
    checks++;
    if ({n_save, n_trig, n_clear, n_done, n_ldrise, n_psce_bad} !== {32'd131, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL conv1_counts: save=%0d trig=%0d clear=%0d done=%0d ld=%0d psce_bad=%0d want 131 1 0 1 1 0",
        n_save, n_trig, n_clear, n_done, n_ldrise, n_psce_bad);
    end
  endtask

  task automatic test_conv2();
    clr_counts(1'b1);
    do_start(1'b1, 4'd2, 5'd11, 5'd12);
    checks++;
    if ({busy, ps_clear, ld_req, ps_ce} !== 4'b1101) begin
      errors++; $display("FAIL conv2_cycle1: busy,clear,ld_req,ce=%b want 1101", {busy, ps_clear, ld_req, ps_ce});
    end
    tick();
    checks++;
    if ({ps_clear, ld_req} !== 2'b01) begin
      errors++; $display("FAIL conv2_cycle2: clear,ld_req=%b want 01", {ps_clear, ld_req});
    end
    run_chan(0, 132, -1, 1'b0, 1'b0);
    run_chan(1, 132, -1, 1'b0, 1'b0);
    run_chan(2, 132, -1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({busy, done, conv_layer, err} !== 4'b0010) begin
      errors++; $display("FAIL conv2_end: busy,done,layer,err=%b want 0010", {busy, done, conv_layer, err});
    end
    checks++;
    if ({n_save, n_trig, n_clear, n_done, n_ldrise, n_psce_bad} !== {32'd393, 32'd3, 32'd1, 32'd1, 32'd3, 32'd0}) begin
      errors++; $display("FAIL conv2_counts: save=%0d trig=%0d clear=%0d done=%0d ld=%0d psce_bad=%0d want 393 3 1 1 3 0",
        n_save, n_trig, n_clear, n_done, n_ldrise, n_psce_bad);
    end
    checks++;
    if (cyc_clear + 1 != cyc_ld) begin
      errors++; $display("FAIL conv2_clear_order: clear cycle %0d ld cycle %0d want ld one later", cyc_clear, cyc_ld);
    end
  endtask

  task automatic test_mismatch();
    clr_counts(1'b0);
    do_start(1'b0, 4'd0, 5'd4, 5'd3);
    run_chan(0, 12, 5, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL mismatch_err_at_done: got %b want 1", err); end
    tick();
    checks++;
    if ({busy, err} !== 2'b01) begin errors++; $display("FAIL mismatch_err_hold: busy,err=%b want 01", {busy, err}); end
    do_start(1'b0, 4'd0, 5'd2, 5'd2);
    checks++;
    if ({busy, err} !== 2'b10) begin errors++; $display("FAIL mismatch_err_clear: busy,err=%b want 10", {busy, err}); end
    run_chan(0, 4, -1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({n_done, n_save} !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL mismatch_counts: done=%0d save=%0d want 2 14", n_done, n_save);
    end
  endtask

  task automatic test_abort();
    clr_counts(1'b1);
    do_start(1'b1, 4'd2, 5'd2, 5'd2);
    run_chan(0, 4, -1, 1'b0, 1'b0);
    checks++;
    if ({ld_req, ld_chan} !== 5'b10001) begin errors++; $display("FAIL abort_pre: ld_req,ld_chan=%b want 10001", {ld_req, ld_chan}); end
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, ld_req, ps_ce, done, conv_trigger} !== 5'b00000) begin
      errors++; $display("FAIL abort_idle: busy,ld_req,ce,done,trig=%b want 00000", {busy, ld_req, ps_ce, done, conv_trigger});
    end
    repeat (3) tick();
    checks++;
    if ({busy, conv_layer, n_done} !== {2'b01, 32'd0}) begin
      errors++; $display("FAIL abort_after: busy=%b layer=%b done_cnt=%0d want 0 1 0", busy, conv_layer, n_done);
    end
  endtask

  task automatic test_spurious();
    clr_counts(1'b0);
    do_start(1'b0, 4'd0, 5'd3, 5'd2);
    run_chan(0, 6, -1, 1'b1, 1'b1);
    tick();
    checks++;
    if ({busy, err, n_save, n_done, n_trig, n_clear, n_psce_bad} !== {2'b00, 32'd5, 32'd1, 32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL spur_end: busy=%b err=%b save=%0d done=%0d trig=%0d clear=%0d psce_bad=%0d want 0 0 5 1 1 0 0",
        busy, err, n_save, n_done, n_trig, n_clear, n_psce_bad);
    end
  endtask

  task automatic test_reset_mid();
    clr_counts(1'b1);
    do_start(1'b1, 4'd0, 5'd3, 5'd3);
    tick();
    ld_ack = 1'b1; tick(); ld_ack = 1'b0; tick();
    conv_valid = 1'b1; conv_addr = 8'd1; tick(); conv_valid = 1'b0; tick();
    checks++;
    if ({busy, err, conv_layer} !== 3'b111) begin
      errors++; $display("FAIL rstmid_pre: busy,err,layer=%b want 111", {busy, err, conv_layer});
    end
    #2 rst_n = 1'b0; #1;
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL rstmid_async: got %b want 0", outs); end
    tick(); rst_n = 1'b1;
    clr_counts(1'b0);
    do_start(1'b0, 4'd0, 5'd2, 5'd2);
    run_chan(0, 4, -1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({busy, err, n_save, n_done} !== {2'b00, 32'd3, 32'd1}) begin
      errors++; $display("FAIL rstmid_rerun: busy=%b err=%b save=%0d done=%0d want 0 0 3 1", busy, err, n_save, n_done);
    end
  endtask

  initial begin
    cyc = 0; ld_prev = 1'b0; clr_counts(1'b0);
    test_reset();
    test_conv1();
    test_conv2();
    test_mismatch();
    test_abort();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
